// File: rtl/add_arbiter.sv
// add_arbiter: round-robin sharing of a single add10 adder between N
// position-update requesters. One grant per clock; the grant and the adder
// operands are combinational, and the adder result is registered one cycle
// later together with the owning requester index.
//
// Optional build macro ADD_SAT_EN: when defined, a carry-out saturates the
// registered sum to all ones (screen-edge clamp); rsp_carry still reports 1.
// When undefined, the sum wraps modulo 2^W.
module add_arbiter #(
  parameter int N = 4,
  parameter int W = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       op_a,
  input  logic [N*W-1:0]       op_b,
  output logic [N-1:0]         gnt,
  output logic [W-1:0]         add_a,
  output logic [W-1:0]         add_b,
  input  logic [W-1:0]         add_s,
  input  logic                 add_c,
  output logic                 rsp_valid,
  output logic [$clog2(N)-1:0] rsp_id,
  output logic [W-1:0]         rsp_sum,
  output logic                 rsp_carry
);

  localparam int IW  = $clog2(N);
  localparam int IW1 = IW + 1;

  logic [IW-1:0] rr_ptr_q,    rr_ptr_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [IW-1:0] rsp_id_q,    rsp_id_d;
  logic [W-1:0]  rsp_sum_q,   rsp_sum_d;
  logic          rsp_carry_q, rsp_carry_d;

  logic          grant_any;
  logic [IW-1:0] grant_idx;
  logic [IW:0]   scan_ix;
  logic [W-1:0]  sum_sel;

  // Round-robin scan: first asserted req at or above rr_ptr, wrapping to 0.
  // The wrap is a conditional subtract so non-power-of-two N works as well.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_ix   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_ix = {1'b0, rr_ptr_q} + IW1'(k);
      if (scan_ix >= IW1'(N)) begin
        scan_ix = scan_ix - IW1'(N);
      end
      if (!grant_any && req[scan_ix[IW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = scan_ix[IW-1:0];
      end
    end
    // No grant may be issued while reset is held.
    if (reset) begin
      grant_any = 1'b0;
    end
  end

  // One-hot grant and operand mux toward the shared adder; zero when idle.
  always_comb begin
    gnt   = '0;
    add_a = '0;
    add_b = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_any && (grant_idx == IW'(i))) begin
        gnt[i] = 1'b1;
        add_a  = op_a[i*W +: W];
        add_b  = op_b[i*W +: W];
      end
    end
  end

  // Sum as captured on a grant edge: optionally clamped on carry-out.
  always_comb begin
`ifdef ADD_SAT_EN
    sum_sel = add_c ? '1 : add_s;
`else
    sum_sel = add_s;
`endif
  end

  // Next state: advance pointer past the winner and capture the response;
  // idle cycles only clear rsp_valid and keep everything else.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    if (grant_any) begin
      rr_ptr_d    = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_idx;
      rsp_sum_d   = sum_sel;
      rsp_carry_d = add_c;
    end
  end

  // State and response registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;

endmodule
